// File: rtl/grf_wb_arbiter.sv
// rtl/grf_wb_arbiter.sv - GRF write-port arbiter between pipeline writeback and buffered MDU results
//
// Purpose: multiplexes the single GRF write port between the pipeline WB
// stage and a small FIFO of MDU results. A starvation counter forces a
// pipeline stall so buffered results drain, and a 32-entry busy scoreboard
// reports which registers still have an MDU result outstanding.
//
// Ports:
//   clk, reset                        clock, asynchronous active-low reset
//   pl_we, pl_wa, pl_wd, pl_stall     pipeline WB request and stall
//   md_issue, md_issue_wa             MDU issue (sets busy bit)
//   md_valid, md_ready, md_wa, md_wd  MDU result handshake
//   q_ra1, q_ra2, q_busy1, q_busy2    scoreboard queries
//   grf_we, grf_wa, grf_wd            GRF write port

module grf_wb_arbiter #(
    parameter int DEPTH    = 2,
    parameter int MAX_WAIT = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pl_we,
    input  logic [4:0]  pl_wa,
    input  logic [31:0] pl_wd,
    output logic        pl_stall,
    input  logic        md_issue,
    input  logic [4:0]  md_issue_wa,
    input  logic        md_valid,
    output logic        md_ready,
    input  logic [4:0]  md_wa,
    input  logic [31:0] md_wd,
    input  logic [4:0]  q_ra1,
    input  logic [4:0]  q_ra2,
    output logic        q_busy1,
    output logic        q_busy2,
    output logic        grf_we,
    output logic [4:0]  grf_wa,
    output logic [31:0] grf_wd
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int WW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

    logic [4:0]    wa_mem [DEPTH];
    logic [31:0]   wd_mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic [WW-1:0] wait_cnt;
    logic [31:0]   busy;
    logic [31:0]   busy_nxt;

    logic empty;
    logic full;
    logic pl_req;
    logic force_drain;
    logic deq;
    logic store;

    assign empty = (count == '0);
    assign full  = (count == FULL_CNT);

    // Ready comes from the registered count only, so a same-cycle drain
    // never opens a slot early.
    assign md_ready = !full;

    // Results for $0 are acknowledged but never occupy a slot.
    assign store = md_valid && md_ready && (md_wa != 5'd0);

    // The pipeline request is masked during reset so the port stays quiet.
    assign pl_req      = reset && pl_we && (pl_wa != 5'd0);
    assign force_drain = !empty && (wait_cnt == WAIT_LIM);
    assign deq         = !empty && (force_drain || !pl_req);
    assign pl_stall    = force_drain;

    always_comb begin
        grf_we = 1'b0;
        grf_wa = 5'd0;
        grf_wd = 32'd0;
        if (deq) begin
            grf_we = 1'b1;
            grf_wa = wa_mem[rd_ptr];
            grf_wd = wd_mem[rd_ptr];
        end else if (pl_req) begin
            grf_we = 1'b1;
            grf_wa = pl_wa;
            grf_wd = pl_wd;
        end
    end

    // Clear on drain first, then set on issue, so a same-cycle set wins.
    always_comb begin
        busy_nxt = busy;
        if (deq) begin
            busy_nxt[wa_mem[rd_ptr]] = 1'b0;
        end
        if (md_issue && (md_issue_wa != 5'd0)) begin
            busy_nxt[md_issue_wa] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    assign q_busy1 = busy[q_ra1];
    assign q_busy2 = busy[q_ra2];

    // Storage needs no reset: an entry is only read while count says it is valid.
    always_ff @(posedge clk) begin
        if (store) begin
            wa_mem[wr_ptr] <= md_wa;
            wd_mem[wr_ptr] <= md_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
            wait_cnt <= '0;
            busy     <= '0;
        end else begin
            if (store) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({store, deq})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (empty || deq) begin
                wait_cnt <= '0;
            end else if (wait_cnt != WAIT_LIM) begin
                wait_cnt <= wait_cnt + WW'(1);
            end
            busy <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// tb/tb_grf_wb_arbiter.sv - self-checking bench for grf_wb_arbiter

module tb_grf_wb_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        pl_we;
    logic [4:0]  pl_wa;
    logic [31:0] pl_wd;
    logic        pl_stall;
    logic        md_issue;
    logic [4:0]  md_issue_wa;
    logic        md_valid;
    logic        md_ready;
    logic [4:0]  md_wa;
    logic [31:0] md_wd;
    logic [4:0]  q_ra1;
    logic [4:0]  q_ra2;
    logic        q_busy1;
    logic        q_busy2;
    logic        grf_we;
    logic [4:0]  grf_wa;
    logic [31:0] grf_wd;

    int n_checks = 0;
    int n_errors = 0;

    // Expected GRF writes, in order, as {wa, wd}.
    logic [36:0] sb [$];

    grf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .pl_we       (pl_we),
        .pl_wa       (pl_wa),
        .pl_wd       (pl_wd),
        .pl_stall    (pl_stall),
        .md_issue    (md_issue),
        .md_issue_wa (md_issue_wa),
        .md_valid    (md_valid),
        .md_ready    (md_ready),
        .md_wa       (md_wa),
        .md_wd       (md_wd),
        .q_ra1       (q_ra1),
        .q_ra2       (q_ra2),
        .q_busy1     (q_busy1),
        .q_busy2     (q_busy2),
        .grf_we      (grf_we),
        .grf_wa      (grf_wa),
        .grf_wd      (grf_wd)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    task automatic pl_drive(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        pl_we = we;
        pl_wa = wa;
        pl_wd = wd;
    endtask

    task automatic push_exp(input logic [4:0] wa, input logic [31:0] wd);
        sb.push_back({wa, wd});
    endtask

    // Every observed GRF write must match the next expected write.
    always @(negedge clk) begin
        if (grf_we === 1'b1) begin
            if (sb.size() == 0) begin
                check_val("write_unexpected", 32'(grf_we), 32'd0);
            end else begin
                logic [36:0] e;
                e = sb.pop_front();
                check_val("wr_wa", 32'(grf_wa), 32'(e[36:32]));
                check_val("wr_wd", grf_wd, e[31:0]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset       = 1'b0;
        pl_drive(1'b0, 5'd0, 32'd0);
        md_issue    = 1'b0;
        md_issue_wa = 5'd0;
        md_valid    = 1'b1;
        md_wa       = 5'd7;
        md_wd       = 32'h7777;
        q_ra1       = 5'd8;
        q_ra2       = 5'd7;

        // Reset and idle
        smp();
        check_val("rst_md_ready", 32'(md_ready), 32'd1);
        check_val("rst_grf_we", 32'(grf_we), 32'd0);
        check_val("rst_pl_stall", 32'(pl_stall), 32'd0);
        check_val("rst_busy1", 32'(q_busy1), 32'd0);
        check_val("rst_busy2", 32'(q_busy2), 32'd0);
        tick();
        md_valid = 1'b0;
        reset    = 1'b1;
        for (int i = 0; i < 3; i++) begin
            smp();
            check_val("idle_grf_we", 32'(grf_we), 32'd0);
            tick();
        end

        // Pipeline only
        pl_drive(1'b1, 5'd5, 32'h1234);
        push_exp(5'd5, 32'h1234);
        smp();
        check_val("pl_grf_we", 32'(grf_we), 32'd1);
        check_val("pl_grf_wa", 32'(grf_wa), 32'd5);
        check_val("pl_grf_wd", grf_wd, 32'h1234);
        tick();
        pl_drive(1'b1, 5'd0, 32'hdead);
        smp();
        check_val("pl_r0_we", 32'(grf_we), 32'd0);
        tick();
        pl_drive(1'b0, 5'd0, 32'd0);

        // Issue / drain scoreboard
        md_issue    = 1'b1;
        md_issue_wa = 5'd8;
        smp();
        check_val("busy8_not_bypassed", 32'(q_busy1), 32'd0);
        tick();
        md_issue = 1'b0;
        smp();
        check_val("busy8_set", 32'(q_busy1), 32'd1);
        tick();
        md_valid = 1'b1;
        md_wa    = 5'd8;
        md_wd    = 32'hcafe;
        push_exp(5'd8, 32'hcafe);
        smp();
        check_val("no_bypass_we", 32'(grf_we), 32'd0);
        tick();
        md_valid = 1'b0;
        smp();
        check_val("drain_we", 32'(grf_we), 32'd1);
        check_val("drain_wa", 32'(grf_wa), 32'd8);
        check_val("busy8_until_edge", 32'(q_busy1), 32'd1);
        tick();
        smp();
        check_val("busy8_cleared", 32'(q_busy1), 32'd0);
        tick();

        // Starvation: entry for r9 vs continuous pipeline requests
        md_valid = 1'b1;
        md_wa    = 5'd9;
        md_wd    = 32'h9999;
        pl_drive(1'b1, 5'd1, 32'h101);
        push_exp(5'd1, 32'h101);
        smp();
        tick();
        md_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pl_drive(1'b1, 5'(2 + i), 32'(32'h102 + i));
            push_exp(5'(2 + i), 32'(32'h102 + i));
            smp();
            check_val("starve_pl_wins", 32'(pl_stall), 32'd0);
            tick();
        end
        pl_drive(1'b1, 5'd5, 32'h105);
        push_exp(5'd9, 32'h9999);
        push_exp(5'd5, 32'h105);
        smp();
        check_val("force_stall", 32'(pl_stall), 32'd1);
        check_val("force_wa", 32'(grf_wa), 32'd9);
        tick();
        smp();
        check_val("retry_stall", 32'(pl_stall), 32'd0);
        check_val("retry_wa", 32'(grf_wa), 32'd5);
        tick();

        // FIFO full with a held third result
        md_valid = 1'b1;
        md_wa    = 5'd10;
        md_wd    = 32'ha0;
        pl_drive(1'b1, 5'd1, 32'h201);
        push_exp(5'd1, 32'h201);
        smp();
        check_val("full_ready_a", 32'(md_ready), 32'd1);
        tick();
        md_wa = 5'd11;
        md_wd = 32'hb0;
        pl_drive(1'b1, 5'd2, 32'h202);
        push_exp(5'd2, 32'h202);
        smp();
        check_val("full_ready_b", 32'(md_ready), 32'd1);
        tick();
        md_wa = 5'd12;
        md_wd = 32'hc0;
        pl_drive(1'b1, 5'd3, 32'h203);
        push_exp(5'd3, 32'h203);
        smp();
        check_val("full_ready_c", 32'(md_ready), 32'd0);
        tick();
        pl_drive(1'b1, 5'd4, 32'h204);
        push_exp(5'd4, 32'h204);
        smp();
        check_val("full_ready_d", 32'(md_ready), 32'd0);
        check_val("full_stall_d", 32'(pl_stall), 32'd0);
        tick();
        pl_drive(1'b1, 5'd5, 32'h205);
        push_exp(5'd10, 32'ha0);
        push_exp(5'd5, 32'h205);
        smp();
        check_val("full_force_stall", 32'(pl_stall), 32'd1);
        check_val("full_force_wa", 32'(grf_wa), 32'd10);
        check_val("full_ready_e", 32'(md_ready), 32'd0);
        tick();
        smp();
        check_val("full_ready_f", 32'(md_ready), 32'd1);
        check_val("full_retry_wa", 32'(grf_wa), 32'd5);
        tick();
        md_valid = 1'b0;
        pl_drive(1'b0, 5'd0, 32'd0);
        push_exp(5'd11, 32'hb0);
        push_exp(5'd12, 32'hc0);
        smp();
        check_val("drain_11", 32'(grf_wa), 32'd11);
        tick();
        smp();
        check_val("drain_12", 32'(grf_wa), 32'd12);
        tick();

        // Async reset with two entries buffered and busy bits set
        q_ra1       = 5'd20;
        q_ra2       = 5'd21;
        md_issue    = 1'b1;
        md_issue_wa = 5'd20;
        pl_drive(1'b1, 5'd1, 32'h301);
        push_exp(5'd1, 32'h301);
        smp();
        tick();
        md_issue_wa = 5'd21;
        md_valid    = 1'b1;
        md_wa       = 5'd20;
        md_wd       = 32'h2020;
        pl_drive(1'b1, 5'd2, 32'h302);
        push_exp(5'd2, 32'h302);
        smp();
        tick();
        md_issue = 1'b0;
        md_wa    = 5'd21;
        md_wd    = 32'h2121;
        pl_drive(1'b1, 5'd3, 32'h303);
        push_exp(5'd3, 32'h303);
        smp();
        tick();
        md_valid = 1'b0;
        pl_drive(1'b1, 5'd4, 32'h304);
        push_exp(5'd4, 32'h304);
        smp();
        check_val("pre_rst_busy20", 32'(q_busy1), 32'd1);
        check_val("pre_rst_busy21", 32'(q_busy2), 32'd1);
        check_val("pre_rst_ready", 32'(md_ready), 32'd0);
        #2;
        reset = 1'b0;
        pl_drive(1'b0, 5'd0, 32'd0);
        #1;
        check_val("arst_ready", 32'(md_ready), 32'd1);
        check_val("arst_busy20", 32'(q_busy1), 32'd0);
        check_val("arst_busy21", 32'(q_busy2), 32'd0);
        check_val("arst_grf_we", 32'(grf_we), 32'd0);
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 6; i++) begin
            smp();
            check_val("post_rst_no_write", 32'(grf_we), 32'd0);
            tick();
        end

        check_val("sb_drained", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/grf_wb_arbiter.md
Name: grf_wb_arbiter

Overview:
- Shares the single GRF write port (we/wa/wd) between two writers: the in-order pipeline writeback stage and the multi-cycle multiply/divide unit (MDU).
- MDU results are buffered in a small FIFO and drained into free write-port cycles.
- A starvation counter can force a pipeline stall so buffered MDU results drain.
- A per-register busy scoreboard tells the hazard unit which GRF registers still have an MDU result pending.

Parameters:
- DEPTH, 2, MDU result FIFO entries; power of 2, at least 2.
- MAX_WAIT, 3, cycles a non-empty FIFO may be denied before a forced drain; at least 1.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- pl_we  in  1  pipeline WB write request.
- pl_wa  in  5  pipeline WB destination register.
- pl_wd  in  32  pipeline WB data.
- pl_stall  out  1  freeze pipeline this cycle; WB holds its request.
- md_issue  in  1  MDU op with a GRF destination issued this cycle.
- md_issue_wa  in  5  destination register of the issued op.
- md_valid  in  1  MDU result valid.
- md_ready  out  1  FIFO can accept a result.
- md_wa  in  5  MDU result destination register.
- md_wd  in  32  MDU result data.
- q_ra1  in  5  scoreboard query address 1.
- q_ra2  in  5  scoreboard query address 2.
- q_busy1  out  1  busy bit of q_ra1 (combinational).
- q_busy2  out  1  busy bit of q_ra2 (combinational).
- grf_we  out  1  GRF write enable.
- grf_wa  out  5  GRF write address.
- grf_wd  out  32  GRF write data.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO emptied; pointers and count cleared.
  - Starvation counter cleared; all 32 busy bits cleared.
  - Outputs settle to md_ready=1, pl_stall=0, grf_we=0, grf_wa=0, grf_wd=0, q_busy*=0.
  - Reset asserted mid-operation discards all buffered results.
- Pipeline request: pl_req = pl_we && pl_wa!=0. A write to $0 is never a request and never reaches grf_we.
- FIFO enqueue:
  - Occurs when md_valid && md_ready.
  - md_ready = !full, computed from the registered count only; it does not depend on a same-cycle dequeue.
  - A result with md_wa==0 is accepted but not stored (silently dropped).
- force = !empty && (wait_cnt == MAX_WAIT).
- Write-port arbitration (combinational, each cycle):
  - force=1: pl_stall=1; port driven from the FIFO head; head dequeued at the clock edge. The pipeline request is retried next cycle.
  - force=0, pl_req=1: port driven from the pipeline; pl_stall=0.
  - force=0, pl_req=0, FIFO non-empty: port driven from the FIFO head; head dequeued.
  - Otherwise grf_we=0, and grf_wa/grf_wd=0.
- There is no same-cycle bypass: an entry enqueued this cycle can be written no earlier than the next cycle.
- Starvation counter wait_cnt:
  - Cleared on any dequeue, or whenever the FIFO is empty.
  - Incremented when the FIFO is non-empty and not dequeued (saturates at MAX_WAIT).
  - Consequence: a buffered result is written at most MAX_WAIT+1 cycles after it reaches the head.
- Simultaneous enqueue and dequeue: both take effect and count is unchanged. When full, no enqueue occurs (md_ready=0).
- Pointers wrap modulo DEPTH.
- Scoreboard:
  - md_issue with md_issue_wa!=0 sets busy[md_issue_wa] at the clock edge.
  - A FIFO dequeue clears busy[head wa].
  - Set and clear of the same register in one cycle: set wins.
  - busy[0] is always 0.
  - q_busy reflects the registered state; it is not bypassed.
- Preconditions on the hazard unit (outside this block):
  - It does not issue an MDU op to a register that is already busy.
  - It does not let the pipeline write a busy register.
  - If violated: the busy bit clears on the first matching drain, and write order follows the arbitration above.

Test Plan:
- Reset and idle: reset=0 with md_valid=1 -> md_ready=1, grf_we=0, pl_stall=0, all q_busy=0. After release, no write occurs until a request arrives.
- Pipeline only: pl_we=1, pl_wa=5, pl_wd=0x1234 -> same-cycle grf_we=1, grf_wa=5, grf_wd=0x1234. pl_wa=0 -> grf_we=0.
- Issue/drain scoreboard: md_issue, md_issue_wa=8 -> q_busy(8)=1 next cycle. md_valid with wa=8, wd=0xCAFE while the pipeline is idle -> written the following cycle; busy(8)=0 after that edge.
- Starvation, MAX_WAIT=3: FIFO holds wa=9 while pl_req=1 every cycle -> pipeline wins 3 cycles. 4th cycle: pl_stall=1, grf_wa=9; pipeline write appears the cycle after.
- FIFO full, DEPTH=2: enqueue two results under continuous pl_req -> md_ready=0. A third md_valid is held, not lost, and accepted the cycle after a forced drain.
- Async reset with 2 entries buffered and busy bits set: reset=0 between edges -> md_ready=1 and q_busy=0 immediately. No buffered write ever appears.
